piso_tx_reg: RTL and testbench

PISO_TX_REG -- requirements
Module: piso_tx_reg

---
 rtl/piso_tx_pkg.sv | 24 ++
 rtl/piso_tx_reg_if.sv | 29 ++
 rtl/piso_bit_counter.sv | 42 ++++
 rtl/piso_tx_reg.sv | 90 +++++++++
 tb/tb_piso_tx_reg.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the PISO serial transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the FSM state enumeration and the default frame width.
package piso_tx_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of serial cycles per frame for an n-bit payload.
  function automatic int frame_len(input int n);
`ifdef PISO_TX_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/piso_tx_reg_if.sv
// Handshake/serial bundle between a frame source and the PISO transmitter.
// Latency: n/a (wires only).
// Backpressure: source may only load while ready is high; loads otherwise dropped.
//
// Signals: I (parallel frame), load (frame request), ready (idle),
//          sout (serial bit), sout_valid (bit qualifier), done (end-of-frame pulse).
// master = frame source, slave = transmitter.
interface piso_tx_reg_if
  import piso_tx_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic [N-1:0] I;
  logic         load;
  logic         ready;
  logic         sout;
  logic         sout_valid;
  logic         done;

  modport master (
    output I, load,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  I, load,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Bit counter for the PISO frame with terminal-count flag.
// Latency: count updates on the posedge after clr/en; tc is registered-state decode.
// Backpressure: none; counts only while en is high, clr has priority.
//
// Ports: clk, rst (async active-high), clr (synchronous clear), en (increment),
//        tc (high while the count equals TC).
module piso_bit_counter #(
  parameter int W  = 3,
  parameter int TC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_V);

endmodule

// File: rtl/piso_tx_reg.sv
// Parallel-in serial-out transmitter: loads an N-bit frame, shifts it out MSB first.
// Latency: first bit in the cycle after the accepting edge; done one cycle after the last bit.
// Backpressure: ready low while shifting; load is ignored (not queued) when ready is low.
//
// Ports: clk, rst (async active-high), bus (piso_tx_reg_if.slave: I, load -> ready,
//        sout, sout_valid, done). Optional macro PISO_TX_PARITY_EN appends an
//        even-parity bit after the data bits.
module piso_tx_reg
  import piso_tx_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  piso_tx_reg_if.slave      bus
);

  localparam int F  = frame_len(N);
  localparam int CW = $clog2(N + 2);

  state_t       state_q, state_d;
  logic [F-1:0] shreg_q, shreg_d;
  logic         done_q, done_d;
  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_tc;

  piso_bit_counter #(
    .W  (CW),
    .TC (F - 1)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          // Parity rides in the LSB so it falls out after the data bits.
`ifdef PISO_TX_PARITY_EN
          shreg_d = {bus.I, ^bus.I};
`else
          shreg_d = bus.I;
`endif
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[F-2:0], 1'b0};
        cnt_en  = 1'b1;
        if (cnt_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign bus.ready      = (state_q == IDLE);
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout       = (state_q == SHIFT) & shreg_q[F-1];
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_tx_reg.sv
// Directed self-checking bench for piso_tx_reg at N=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_piso_tx_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  piso_tx_reg_if #(.N(4)) bus ();

  piso_tx_reg #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {ready, sout_valid, sout, done} against the expected vector.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.ready, bus.sout_valid, bus.sout, bus.done};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed rdy/vld/sout/done=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at the first bit cycle of a frame; ends after checking the done cycle.
  task automatic expect_frame(input string tag, input logic [3:0] bits);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), {1'b0, 1'b1, bits[3-i], 1'b0});
      step();
    end
`ifdef PISO_TX_PARITY_EN
    chk($sformatf("%s_parity", tag), {1'b0, 1'b1, ^bits, 1'b0});
    step();
`endif
    chk($sformatf("%s_done", tag), 4'b1001);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.I    = 4'b0000;
    bus.load = 1'b0;

    // Reset state, with load asserted to show it is held off during reset.
    #2;
    chk("reset_async", 4'b1000);
    bus.load = 1'b1;
    step();
    chk("reset_hold", 4'b1000);
    rst      = 1'b0;
    bus.load = 1'b0;
    step();
    chk("idle_after_reset", 4'b1000);

    // Basic frame 1011.
    bus.I    = 4'b1011;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.I    = 4'b0000;
    expect_frame("f1011", 4'b1011);
    step();
    chk("f1011_idle", 4'b1000);

    // Load during SHIFT is ignored; I changes do not disturb the frame.
    bus.I    = 4'b0110;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("f0110_bit0", 4'b0100);
    step();
    chk("f0110_bit1", 4'b0110);
    bus.I    = 4'b1111;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("f0110_bit2", 4'b0110);
    step();
    chk("f0110_bit3", 4'b0100);
    step();
    chk("f0110_done", 4'b1001);
    step();
    chk("f0110_no_restart", 4'b1000);

    // load held high: back-to-back frames with one idle (done) cycle between.
    bus.I    = 4'b1000;
    bus.load = 1'b1;
    step();
    bus.I = 4'b0001;
    expect_frame("bb1000", 4'b1000);
    step();
    expect_frame("bb0001", 4'b0001);
    bus.load = 1'b0;
    step();
    chk("bb_idle", 4'b1000);

    // Asynchronous reset mid-frame after the second bit.
    bus.I    = 4'b1101;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("rst_bit0", 4'b0110);
    step();
    chk("rst_bit1", 4'b0110);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_frame", 4'b1000);
    step();
    rst = 1'b0;
    chk("rst_held", 4'b1000);
    step();
    chk("rst_no_done", 4'b1000);

    // Clean frame after reset, then parity-0 pattern.
    bus.I    = 4'b0101;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    expect_frame("f0101", 4'b0101);
    bus.I    = 4'b1001;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    expect_frame("f1001", 4'b1001);
    step();
    chk("final_idle", 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
